// File: rtl/stream_xbar_return.sv
// Return-path router: steers id-tagged packets to one of D_COUNT destination
// streams through a single-entry register per destination; out-of-range ids are dropped.
module stream_xbar_return #(
  parameter int T_DATA_WIDTH = 8,
  parameter int D_COUNT      = 3,
  parameter int T_ID___WIDTH = (D_COUNT > 1) ? $clog2(D_COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_ID___WIDTH-1:0] s_id_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [D_COUNT],
  output logic [D_COUNT-1:0]      m_last_o,
  output logic [D_COUNT-1:0]      m_valid_o,
  input  logic [D_COUNT-1:0]      m_ready_i,
  output logic                    drop_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [T_ID___WIDTH:0] D_COUNT_W = D_COUNT[T_ID___WIDTH:0];

  state_t                    state_q, state_d;
  logic [T_ID___WIDTH-1:0]   lock_id_q, lock_id_d;
  logic                      drop_q, drop_d;
  logic [T_DATA_WIDTH-1:0]   m_data_q [D_COUNT];
  logic [T_DATA_WIDTH-1:0]   m_data_d [D_COUNT];
  logic [D_COUNT-1:0]        m_last_q, m_last_d;
  logic [D_COUNT-1:0]        m_valid_q, m_valid_d;

  logic [D_COUNT-1:0]        free_s;
  logic [T_ID___WIDTH-1:0]   tgt_id_s;
  logic                      tgt_free_s;
  logic                      in_range_s;
  logic                      ready_s;
  logic                      wr_en_s;

  // Target selection: the head beat's own id in HEAD, the locked id otherwise.
  always_comb begin
    free_s     = ~m_valid_q | m_ready_i;
    in_range_s = ({1'b0, s_id_i} < D_COUNT_W);
    tgt_id_s   = (state_q == HEAD) ? s_id_i : lock_id_q;
    tgt_free_s = 1'b0;
    for (int d = 0; d < D_COUNT; d++) begin
      if (tgt_id_s == T_ID___WIDTH'(d)) begin
        tgt_free_s = free_s[d];
      end else begin
        tgt_free_s = tgt_free_s;
      end
    end
  end

  // Packet FSM: decides input ready, buffer write and drop pulse.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    drop_d    = 1'b0;
    ready_s   = 1'b0;
    wr_en_s   = 1'b0;
    case (state_q)
      HEAD: begin
        if (in_range_s) begin
          ready_s = tgt_free_s;
          if (s_valid_i && tgt_free_s) begin
            wr_en_s   = 1'b1;
            lock_id_d = s_id_i;
            state_d   = s_last_i ? HEAD : BODY;
          end else begin
            state_d = HEAD;
          end
        end else begin
          ready_s = 1'b1;
          if (s_valid_i) begin
            drop_d  = s_last_i;
            state_d = s_last_i ? HEAD : DROP;
          end else begin
            state_d = HEAD;
          end
        end
      end
      BODY: begin
        ready_s = tgt_free_s;
        if (s_valid_i && tgt_free_s) begin
          wr_en_s = 1'b1;
          state_d = s_last_i ? HEAD : BODY;
        end else begin
          state_d = BODY;
        end
      end
      DROP: begin
        ready_s = 1'b1;
        if (s_valid_i && s_last_i) begin
          drop_d  = 1'b1;
          state_d = HEAD;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = HEAD;
      end
    endcase
  end

  // Destination registers: drain on ready, refill from the input when targeted.
  always_comb begin
    for (int d = 0; d < D_COUNT; d++) begin
      m_valid_d[d] = m_valid_q[d] & ~m_ready_i[d];
      m_last_d[d]  = m_last_q[d];
      m_data_d[d]  = m_data_q[d];
      if (wr_en_s && (tgt_id_s == T_ID___WIDTH'(d))) begin
        m_valid_d[d] = 1'b1;
        m_last_d[d]  = s_last_i;
        m_data_d[d]  = s_data_i;
      end else begin
        m_valid_d[d] = m_valid_d[d];
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HEAD;
      lock_id_q <= '0;
      drop_q    <= 1'b0;
      m_valid_q <= '0;
      m_last_q  <= '0;
      for (int d = 0; d < D_COUNT; d++) begin
        m_data_q[d] <= '0;
      end
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      drop_q    <= drop_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  assign s_ready_o = ready_s;
  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign m_valid_o = m_valid_q;
  assign drop_o    = drop_q;
  assign busy_o    = (state_q != HEAD);

endmodule

// File: tb/tb_stream_xbar_return.sv
// Directed table-driven bench for stream_xbar_return (D_COUNT=3, 8-bit data).
module tb_stream_xbar_return;

  logic       clk;
  logic       rst;
  logic [7:0] s_data;
  logic [1:0] s_id;
  logic       s_last;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data [3];
  logic [2:0] m_last;
  logic [2:0] m_valid;
  logic [2:0] m_ready;
  logic       drop;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  stream_xbar_return #(.T_DATA_WIDTH(8), .D_COUNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (s_data),
    .s_id_i    (s_id),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .drop_o    (drop),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       vld;
    logic [1:0] id;
    logic [7:0] dat;
    logic       lst;
    logic [2:0] rdy;
    logic       e_rdy;
    logic [2:0] e_val;
    logic [2:0] e_last;
    logic [7:0] e_d0;
    logic [7:0] e_d1;
    logic [7:0] e_d2;
    logic       e_drop;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] id,
                              input logic [7:0] dat, input logic l, input logic [2:0] rdy,
                              input logic er, input logic [2:0] ev, input logic [2:0] el,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                              input logic edrop, input logic ebusy);
    vec_t t;
    t.rst = r;  t.vld = v;  t.id = id;  t.dat = dat;  t.lst = l;  t.rdy = rdy;
    t.e_rdy = er;  t.e_val = ev;  t.e_last = el;
    t.e_d0 = d0;  t.e_d1 = d1;  t.e_d2 = d2;
    t.e_drop = edrop;  t.e_busy = ebusy;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic [7:0] ed [3];
    ed[0] = t.e_d0;  ed[1] = t.e_d1;  ed[2] = t.e_d2;
    rst = t.rst;  s_valid = t.vld;  s_id = t.id;  s_data = t.dat;
    s_last = t.lst;  m_ready = t.rdy;
    #1;
    if (!t.rst) check("s_ready", idx, {31'd0, s_ready}, {31'd0, t.e_rdy});
    @(posedge clk);
    #1;
    check("m_valid", idx, {29'd0, m_valid}, {29'd0, t.e_val});
    check("drop", idx, {31'd0, drop}, {31'd0, t.e_drop});
    check("busy", idx, {31'd0, busy}, {31'd0, t.e_busy});
    for (int d = 0; d < 3; d++) begin
      if (t.e_val[d]) begin
        check("m_data", idx, {24'd0, m_data[d]}, {24'd0, ed[d]});
        check("m_last", idx, {31'd0, m_last[d]}, {31'd0, t.e_last[d]});
      end
    end
  endtask

  initial begin
    rst = 1'b1;  s_valid = 1'b0;  s_id = 2'd0;  s_data = 8'd0;  s_last = 1'b0;  m_ready = 3'b111;

    // reset, then single-beat packet to destination 1
    vecs.push_back(mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 3'b111, 1'b0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'd1, 8'hA5, 1'b1, 3'b111, 1'b1, 3'b010, 3'b010, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
    // 4-beat packet locked to id 2 even though s_id changes
    vecs.push_back(mk(1'b0, 1'b1, 2'd2, 8'h10, 1'b0, 3'b111, 1'b1, 3'b100, 3'b000, 8'h00, 8'h00, 8'h10, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'd0, 8'h11, 1'b0, 3'b111, 1'b1, 3'b100, 3'b000, 8'h00, 8'h00, 8'h11, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'd0, 8'h12, 1'b0, 3'b111, 1'b1, 3'b100, 3'b000, 8'h00, 8'h00, 8'h12, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'd0, 8'h13, 1'b1, 3'b111, 1'b1, 3'b100, 3'b100, 8'h00, 8'h00, 8'h13, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
    // destination 0 stalled for 5 cycles mid-packet
    vecs.push_back(mk(1'b0, 1'b1, 2'd0, 8'h20, 1'b0, 3'b110, 1'b1, 3'b001, 3'b000, 8'h20, 8'h00, 8'h00, 1'b0, 1'b1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1'b0, 1'b1, 2'd0, 8'h21, 1'b0, 3'b110, 1'b0, 3'b001, 3'b000, 8'h20, 8'h00, 8'h00, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'd0, 8'h21, 1'b0, 3'b111, 1'b1, 3'b001, 3'b000, 8'h21, 8'h00, 8'h00, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'd0, 8'h22, 1'b1, 3'b111, 1'b1, 3'b001, 3'b001, 8'h22, 8'h00, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
    // stalled destination 0 does not block a packet to destination 1
    vecs.push_back(mk(1'b0, 1'b1, 2'd0, 8'h30, 1'b1, 3'b110, 1'b1, 3'b001, 3'b001, 8'h30, 8'h00, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'd1, 8'h31, 1'b0, 3'b110, 1'b1, 3'b011, 3'b001, 8'h30, 8'h31, 8'h00, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'd1, 8'h32, 1'b1, 3'b110, 1'b1, 3'b011, 3'b011, 8'h30, 8'h32, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
    // out-of-range id 3: multi-beat drop, normal routing after, single-beat drop
    vecs.push_back(mk(1'b0, 1'b1, 2'd3, 8'h40, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'd3, 8'h41, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'd3, 8'h42, 1'b1, 3'b111, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'd0, 8'h50, 1'b1, 3'b111, 1'b1, 3'b001, 3'b001, 8'h50, 8'h00, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'd3, 8'h55, 1'b1, 3'b111, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
    // reset in the middle of a BODY packet with buffered data
    vecs.push_back(mk(1'b0, 1'b1, 2'd2, 8'h60, 1'b0, 3'b011, 1'b1, 3'b100, 3'b000, 8'h00, 8'h00, 8'h60, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 2'd2, 8'h61, 1'b0, 3'b011, 1'b0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'd2, 8'h70, 1'b1, 3'b111, 1'b1, 3'b100, 3'b100, 8'h00, 8'h00, 8'h70, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // back-to-back 6-beat packet to destination 1: one beat per cycle
    for (int i = 0; i < 6; i++) begin
      rst = 1'b0;  s_valid = 1'b1;  s_id = 2'd1;  s_data = 8'h80 + 8'(i);
      s_last = (i == 5);  m_ready = 3'b111;
      #1;
      check("stream_ready", 100 + i, {31'd0, s_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("stream_valid", 100 + i, {29'd0, m_valid}, 32'h2);
      check("stream_data", 100 + i, {24'd0, m_data[1]}, 32'h80 + i);
      check("stream_last", 100 + i, {31'd0, m_last[1]}, (i == 5) ? 32'd1 : 32'd0);
    end
    s_valid = 1'b0;  s_id = 2'd0;
    @(posedge clk);
    #1;
    check("stream_drain", 106, {29'd0, m_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
